// File: rtl/ilv_pingpong_ctrl.sv
// ============================================================================
// Module   : ilv_pingpong_ctrl
// Brief    : Ping-pong bank sequencer for a ROWS x COLS block (de)interleaver.
//            Define ILV_FRAME_CNT_EN to add the frame_cnt output.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ilv_pingpong_ctrl #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int DEPTH = ROWS * COLS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          mem_we,
    output logic          mem_wbank,
    output logic [AW-1:0] mem_waddr,
    output logic          mem_re,
    output logic          mem_rbank,
    output logic [AW-1:0] mem_raddr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sof,
    output logic          out_eof,
    output logic          busy
`ifdef ILV_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

    logic [AW-1:0] r_wcnt;
    logic [AW-1:0] r_rcnt;
    logic [AW-1:0] r_raddr;
    logic [AW-1:0] r_minor;
    logic [AW-1:0] r_major;
    logic          r_wbank;
    logic          r_rbank;
    logic [1:0]    r_full;
    logic [1:0]    r_bmode;
    logic          r_out_valid;
    logic          r_out_sof;
    logic          r_out_eof;

    logic          w_wr;
    logic          w_wlast;
    logic          w_rd;
    logic          w_rlast;
    logic          w_rmode;
    logic [AW-1:0] w_inner;
    logic [AW-1:0] w_stride;
    logic [AW-1:0] w_raddr_nxt;
    logic [AW-1:0] w_minor_nxt;
    logic [AW-1:0] w_major_nxt;
    logic [1:0]    w_full_nxt;

    assign in_ready  = ~r_full[r_wbank] & ~flush & ~rst;
    assign w_wr      = in_valid & in_ready;
    assign w_wlast   = w_wr & (r_wcnt == c_LAST);
    assign mem_we    = w_wr;
    assign mem_wbank = r_wbank;
    assign mem_waddr = r_wcnt;

    assign w_rd      = r_full[r_rbank] & (~r_out_valid | out_ready) & ~flush & ~rst;
    assign w_rlast   = w_rd & (r_rcnt == c_LAST);
    assign mem_re    = w_rd;
    assign mem_rbank = r_rbank;
    assign mem_raddr = r_raddr;

    // Transposed walk: step by stride along the inner dimension, then restart at the next major index.
    assign w_rmode  = r_bmode[r_rbank];
    assign w_inner  = w_rmode ? AW'(COLS - 1) : AW'(ROWS - 1);
    assign w_stride = w_rmode ? AW'(ROWS) : AW'(COLS);

    always_comb begin
        w_raddr_nxt = r_raddr + w_stride;
        w_minor_nxt = r_minor + 1'b1;
        w_major_nxt = r_major;
        if (r_minor == w_inner) begin
            w_minor_nxt = '0;
            w_major_nxt = r_major + 1'b1;
            w_raddr_nxt = r_major + 1'b1;
        end
        if (r_rcnt == c_LAST) begin
            w_minor_nxt = '0;
            w_major_nxt = '0;
            w_raddr_nxt = '0;
        end
    end

    // Write completion and read drain always target different banks.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wlast) begin
            w_full_nxt[r_wbank] = 1'b1;
        end
        if (w_rlast) begin
            w_full_nxt[r_rbank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_raddr     <= '0;
            r_minor     <= '0;
            r_major     <= '0;
            r_wbank     <= 1'b0;
            r_rbank     <= 1'b0;
            r_full      <= 2'b00;
            r_bmode     <= 2'b00;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
        end else begin
            if (w_wr) begin
                if (r_wcnt == '0) begin
                    r_bmode[r_wbank] <= mode;
                end
                r_wcnt <= w_wlast ? '0 : r_wcnt + 1'b1;
                if (w_wlast) begin
                    r_wbank <= ~r_wbank;
                end
            end
            r_full <= w_full_nxt;
            if (w_rd) begin
                r_rcnt    <= w_rlast ? '0 : r_rcnt + 1'b1;
                r_raddr   <= w_raddr_nxt;
                r_minor   <= w_minor_nxt;
                r_major   <= w_major_nxt;
                r_out_sof <= (r_rcnt == '0);
                r_out_eof <= (r_rcnt == c_LAST);
                if (w_rlast) begin
                    r_rbank <= ~r_rbank;
                end
            end
            r_out_valid <= w_rd ? 1'b1 : (out_ready ? 1'b0 : r_out_valid);
        end
    end

    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign out_eof   = r_out_eof;
    assign busy      = r_full[0] | r_full[1] | (r_wcnt != '0) | r_out_valid;

`ifdef ILV_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_frame_cnt <= '0;
        end else if (r_out_valid && out_ready && r_out_eof) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

`default_nettype wire
